// File: rtl/frame_traffic_gen.sv
// Frame traffic generator: emits frames of constant payload per priority class,
// round-robin over all classes (mode 0) or on one fixed class (mode 1), with a
// configurable idle gap after each round (mode 0) or after each frame (mode 1).
//
// Ports:
//   clk_sys, reset      single clock, synchronous active-high reset
//   start, stop, hold   run request, graceful stop, stall
//   mode, fixed_class   class selection policy, latched at start
//   num_frames          frames per run (0 = continuous), latched at start
//   len_cfg, seed_cfg   per-class frame length / first payload, latched at start
//   gap_cfg             idle cycles after each round, latched at start
//   data_out, data_valid, frame_valid, ctrl_out, prio_out, hi_priority
//                       registered beat outputs
//   busy, done, frame_cnt
//                       run status
module frame_traffic_gen #(
  parameter int NUM_CLASSES = 2,
  parameter int CLASS_W     = 1,
  parameter int DATA_W      = 8,
  parameter int LEN_W       = 12
) (
  input  logic                          clk_sys,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          stop,
  input  logic                          hold,
  input  logic                          mode,
  input  logic [CLASS_W-1:0]            fixed_class,
  input  logic [15:0]                   num_frames,
  input  logic [NUM_CLASSES*LEN_W-1:0]  len_cfg,
  input  logic [NUM_CLASSES*DATA_W-1:0] seed_cfg,
  input  logic [7:0]                    gap_cfg,
  output logic [DATA_W-1:0]             data_out,
  output logic                          data_valid,
  output logic                          frame_valid,
  output logic [2*LEN_W-1:0]            ctrl_out,
  output logic [CLASS_W-1:0]            prio_out,
  output logic                          hi_priority,
  output logic                          busy,
  output logic                          done,
  output logic [15:0]                   frame_cnt
);

  localparam logic [CLASS_W-1:0] LAST_CLASS = CLASS_W'(NUM_CLASSES - 1);

  typedef enum logic [1:0] {IDLE, FRAME, GAP} state_t;
  state_t state;

  // Configuration latched at start
  logic                                mode_r;
  logic [15:0]                         nf_r;
  logic [NUM_CLASSES-1:0][LEN_W-1:0]   len_r;
  logic [NUM_CLASSES-1:0][DATA_W-1:0]  seed_r;
  logic [7:0]                          gap_r;

  // Run state
  logic [NUM_CLASSES-1:0][DATA_W-1:0]  n_r;
  logic [CLASS_W-1:0]                  cur_class;
  logic [LEN_W-1:0]                    beats_left;
  logic [7:0]                          gap_cnt;
  logic                                first_beat;
  logic                                stop_pend;
  logic                                end_pend;

  // View of the configuration used for the next beat: on the start edge the
  // first beat is issued straight from the inputs, afterwards from the latches.
  logic                                idle_v;
  logic                                sel_mode;
  logic [15:0]                         sel_nf;
  logic [7:0]                          sel_gap;
  logic [NUM_CLASSES-1:0][LEN_W-1:0]   sel_len;
  logic [NUM_CLASSES-1:0][DATA_W-1:0]  sel_seed;
  logic [CLASS_W-1:0]                  sel_class;
  logic [CLASS_W-1:0]                  start_class;
  logic [CLASS_W-1:0]                  nxt_class;
  logic [DATA_W-1:0]                   sel_n;
  logic [15:0]                         sel_fcnt;
  logic [15:0]                         fcnt_inc;
  logic [LEN_W-1:0]                    sel_beats;
  logic [LEN_W-1:0]                    cur_len;
  logic [LEN_W-1:0]                    nxt_len;
  logic                                sel_first;
  logic                                sel_stop;
  logic                                last_beat;
  logic                                finish;
  logic                                gap_req;
  logic                                beat_go;

  function automatic logic [LEN_W-1:0] eff_len(input logic [LEN_W-1:0] l);
    return (l == '0) ? LEN_W'(1) : l;
  endfunction

  always_comb begin
    idle_v      = (state == IDLE);
    start_class = mode ? fixed_class : '0;
    sel_mode    = idle_v ? mode       : mode_r;
    sel_nf      = idle_v ? num_frames : nf_r;
    sel_gap     = idle_v ? gap_cfg    : gap_r;
    sel_len     = idle_v ? len_cfg    : len_r;
    sel_seed    = idle_v ? seed_cfg   : seed_r;
    sel_class   = idle_v ? start_class : cur_class;
    sel_n       = idle_v ? '0 : n_r[sel_class];
    sel_fcnt    = idle_v ? '0 : frame_cnt;
    sel_first   = idle_v | first_beat;
    cur_len     = eff_len(sel_len[sel_class]);
    sel_beats   = idle_v ? cur_len : beats_left;
    // start wins over stop in IDLE
    sel_stop    = !idle_v && (stop || stop_pend);
    fcnt_inc    = sel_fcnt + 16'd1;
    last_beat   = (sel_beats == LEN_W'(1));
    finish      = sel_stop || ((sel_nf != '0) && (fcnt_inc == sel_nf));
    gap_req     = sel_mode || (sel_class == LAST_CLASS);
    if (sel_mode)
      nxt_class = sel_class;
    else if (sel_class == LAST_CLASS)
      nxt_class = '0;
    else
      nxt_class = CLASS_W'(sel_class + 1'b1);
    nxt_len     = eff_len(sel_len[nxt_class]);
    beat_go     = !hold && ((idle_v && start) || (state == FRAME && !end_pend));
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state       <= IDLE;
      data_out    <= '0;
      data_valid  <= 1'b0;
      frame_valid <= 1'b0;
      ctrl_out    <= '0;
      prio_out    <= '0;
      hi_priority <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      frame_cnt   <= '0;
      mode_r      <= 1'b0;
      nf_r        <= '0;
      len_r       <= '0;
      seed_r      <= '0;
      gap_r       <= '0;
      n_r         <= '0;
      cur_class   <= '0;
      beats_left  <= '0;
      gap_cnt     <= '0;
      first_beat  <= 1'b0;
      stop_pend   <= 1'b0;
      end_pend    <= 1'b0;
    end else begin
      done        <= 1'b0;
      data_valid  <= 1'b0;
      frame_valid <= 1'b0;
      ctrl_out    <= '0;
      data_out    <= '0;
      hi_priority <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            mode_r     <= mode;
            nf_r       <= num_frames;
            len_r      <= len_cfg;
            seed_r     <= seed_cfg;
            gap_r      <= gap_cfg;
            n_r        <= '0;
            frame_cnt  <= '0;
            stop_pend  <= 1'b0;
            end_pend   <= 1'b0;
            cur_class  <= start_class;
            beats_left <= sel_beats;
            first_beat <= 1'b1;
            state      <= FRAME;
            busy       <= 1'b1;
          end
        end
        FRAME: begin
          // end_pend marks the cycle after the final beat of a run
          if (end_pend) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b1;
            end_pend  <= 1'b0;
            stop_pend <= 1'b0;
          end else if (stop) begin
            stop_pend <= 1'b1;
          end
        end
        GAP: begin
          if (stop) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (!hold) begin
            if (gap_cnt == 8'd1) begin
              state      <= FRAME;
              cur_class  <= nxt_class;
              beats_left <= nxt_len;
              first_beat <= 1'b1;
            end else begin
              gap_cnt <= gap_cnt - 8'd1;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase

      // Beat issue overrides the per-state defaults above (later NBA wins)
      if (beat_go) begin
        data_valid  <= 1'b1;
        frame_valid <= sel_first;
        ctrl_out    <= sel_first ? {cur_len, cur_len} : '0;
        data_out    <= sel_seed[sel_class] + sel_n;
        prio_out    <= sel_class;
        hi_priority <= (sel_class == '0);
        first_beat  <= 1'b0;
        if (last_beat) begin
          frame_cnt      <= fcnt_inc;
          n_r[sel_class] <= sel_n + 1'b1;
          if (finish) begin
            end_pend <= 1'b1;
          end else if (gap_req && (sel_gap != '0)) begin
            state   <= GAP;
            gap_cnt <= sel_gap;
          end else begin
            cur_class  <= nxt_class;
            beats_left <= nxt_len;
            first_beat <= 1'b1;
          end
        end else begin
          beats_left <= sel_beats - 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_frame_traffic_gen.sv
module tb_frame_traffic_gen;

  localparam int NC = 2;
  localparam int CW = 1;
  localparam int DW = 8;
  localparam int LW = 12;

  logic              clk_sys = 1'b0;
  logic              reset;
  logic              start;
  logic              stop;
  logic              hold;
  logic              mode;
  logic [CW-1:0]     fixed_class;
  logic [15:0]       num_frames;
  logic [NC*LW-1:0]  len_cfg;
  logic [NC*DW-1:0]  seed_cfg;
  logic [7:0]        gap_cfg;
  logic [DW-1:0]     data_out;
  logic              data_valid;
  logic              frame_valid;
  logic [2*LW-1:0]   ctrl_out;
  logic [CW-1:0]     prio_out;
  logic              hi_priority;
  logic              busy;
  logic              done;
  logic [15:0]       frame_cnt;

  frame_traffic_gen #(
    .NUM_CLASSES (NC),
    .CLASS_W     (CW),
    .DATA_W      (DW),
    .LEN_W       (LW)
  ) dut (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .start       (start),
    .stop        (stop),
    .hold        (hold),
    .mode        (mode),
    .fixed_class (fixed_class),
    .num_frames  (num_frames),
    .len_cfg     (len_cfg),
    .seed_cfg    (seed_cfg),
    .gap_cfg     (gap_cfg),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .frame_valid (frame_valid),
    .ctrl_out    (ctrl_out),
    .prio_out    (prio_out),
    .hi_priority (hi_priority),
    .busy        (busy),
    .done        (done),
    .frame_cnt   (frame_cnt)
  );

  always #5 clk_sys = ~clk_sys;

  int cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  typedef struct {
    int data;
    int fv;
    int ctrl;
    int cls;
    int off;
  } beat_t;

  // stop_at/start2_at/rst_at = 0 means unused; hl = 0 means no hold
  typedef struct {
    int mode, fixed, nf, len0, len1, seed0, seed1, gap;
    int hs, hl, stop_at, start2_at, rst_at, ss;
  } vec_t;

  beat_t sb[$];
  vec_t  vt[10];

  int checks = 0;
  int errors = 0;
  bit mon_en = 0;
  int base = 0;
  int done_cnt = 0;
  int done_off = -1;
  int fc_at_done = -1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int map_t(input vec_t v, input int x);
    return x + ((v.hl > 0 && x >= v.hs) ? v.hl : 0);
  endfunction

  // Reference model: pushes every expected beat with its cycle offset from the start edge
  task automatic build_model(input vec_t v, output int exp_done, output int exp_frames);
    int t, frames, cls, len;
    int n[2];
    bit gapreq;
    beat_t b;
    t = 0; frames = 0; n[0] = 0; n[1] = 0;
    cls = v.mode ? v.fixed : 0;
    exp_done = -1; exp_frames = 0;
    forever begin
      len = (cls == 0) ? v.len0 : v.len1;
      if (len == 0) len = 1;
      for (int j = 0; j < len; j++) begin
        b.off = map_t(v, t + j);
        if (v.rst_at > 0 && b.off >= v.rst_at) return;
        b.data = (((cls == 0) ? v.seed0 : v.seed1) + n[cls]) & 'hFF;
        b.fv   = (j == 0) ? 1 : 0;
        b.ctrl = (j == 0) ? ((len << 12) | len) : 0;
        b.cls  = cls;
        sb.push_back(b);
      end
      t += len; frames++; n[cls]++; exp_frames = frames;
      if (v.stop_at > 0 && v.stop_at < t) begin exp_done = map_t(v, t); return; end
      if (v.nf > 0 && frames == v.nf)     begin exp_done = map_t(v, t); return; end
      gapreq = (v.mode != 0) || (cls == NC - 1);
      if (v.mode == 0) cls = (cls == NC - 1) ? 0 : cls + 1;
      if (gapreq && v.gap > 0) begin
        if (v.stop_at > 0 && v.stop_at >= t && v.stop_at < t + v.gap) begin
          exp_done = v.stop_at; return;
        end
        t += v.gap;
      end
    end
  endtask

  // Output monitor / scoreboard consumer
  initial begin
    beat_t e;
    forever begin
      @(negedge clk_sys);
      if (mon_en) begin
        if (done === 1'b1) begin
          done_cnt++;
          done_off   = cyc - base;
          fc_at_done = int'(frame_cnt);
          chk("done_busy", 32'(busy), 0);
        end
        if (data_valid === 1'b1) begin
          if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL extra_beat: got data 0x%0h with no beat expected (t=%0t)", data_out, $time);
          end else begin
            e = sb.pop_front();
            chk("beat_time",  32'(cyc - base), 32'(e.off));
            chk("beat_data",  32'(data_out), 32'(e.data));
            chk("beat_fv",    32'(frame_valid), 32'(e.fv));
            chk("beat_ctrl",  32'(ctrl_out), 32'(e.ctrl));
            chk("beat_prio",  32'(prio_out), 32'(e.cls));
            chk("beat_hi",    32'(hi_priority), (e.cls == 0) ? 1 : 0);
            chk("beat_busy",  32'(busy), 1);
          end
        end else begin
          chk("idle_outputs", 32'({frame_valid, hi_priority, |ctrl_out, |data_out}), 0);
        end
      end
    end
  end

  task automatic run_vec(input int id, input vec_t v);
    int exp_done, exp_frames, budget;
    build_model(v, exp_done, exp_frames);
    budget = (v.rst_at > 0) ? v.rst_at + 3 : exp_done + 4;
    done_cnt = 0; done_off = -1; fc_at_done = -1;
    @(negedge clk_sys);
    mode        = v.mode[0];
    fixed_class = CW'(v.fixed);
    num_frames  = 16'(v.nf);
    len_cfg     = {LW'(v.len1), LW'(v.len0)};
    seed_cfg    = {DW'(v.seed1), DW'(v.seed0)};
    gap_cfg     = 8'(v.gap);
    start       = 1'b1;
    stop        = v.ss[0];
    hold        = 1'b0;
    base        = cyc + 1;
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk_sys);
      start = (k == v.start2_at);
      stop  = (k == v.stop_at);
      hold  = (v.hl > 0 && k >= v.hs && k < v.hs + v.hl);
      reset = (k == v.rst_at);
      if (k == 1) begin
        // scramble the configuration mid-run; the run must not notice
        mode        = ~mode;
        fixed_class = ~fixed_class;
        num_frames  = 16'd1;
        len_cfg     = 24'($urandom);
        seed_cfg    = 16'($urandom);
        gap_cfg     = 8'($urandom);
      end
      if (v.rst_at > 0 && k == v.rst_at + 1)
        chk($sformatf("v%0d_rst_outputs", id),
            32'({data_valid, frame_valid, busy, done, hi_priority,
                 |data_out, |ctrl_out, |prio_out, |frame_cnt}), 0);
      if (v.rst_at > 0 && k == v.rst_at + 3)
        chk($sformatf("v%0d_rst_stays_idle", id), 32'({busy, data_valid}), 0);
    end
    start = 1'b0; stop = 1'b0; hold = 1'b0;
    if (v.rst_at == 0) begin
      chk($sformatf("v%0d_done_time", id), 32'(done_off), 32'(exp_done));
      chk($sformatf("v%0d_done_pulses", id), 32'(done_cnt), 1);
      chk($sformatf("v%0d_frame_cnt", id), 32'(fc_at_done), 32'(exp_frames));
      chk($sformatf("v%0d_busy_after", id), 32'(busy), 0);
    end else begin
      chk($sformatf("v%0d_no_done", id), 32'(done_cnt), 0);
    end
    chk($sformatf("v%0d_beats_missing", id), 32'(sb.size()), 0);
    sb.delete();
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; hold = 1'b0; mode = 1'b0;
    fixed_class = '0; num_frames = '0; len_cfg = '0; seed_cfg = '0; gap_cfg = '0;
    repeat (3) @(negedge clk_sys);
    chk("reset_beat_outputs", 32'({data_valid, frame_valid, hi_priority, |data_out, |ctrl_out}), 0);
    chk("reset_status", 32'({busy, done, |prio_out}), 0);
    chk("reset_frame_cnt", 32'(frame_cnt), 0);
    reset = 1'b0;
    repeat (3) @(negedge clk_sys);
    chk("idle_waits_busy", 32'(busy), 0);
    chk("idle_waits_valid", 32'(data_valid), 0);
    mon_en = 1;

    //          mode fix nf  len0   len1   seed0 seed1 gap hs hl stop st2 rst  ss
    vt[0] = '{0,   0,  4,  'h200, 'h040, 'hF0, 'h00, 10, 0, 0, 0,   0,  0,   0};
    vt[1] = '{1,   1,  2,  5,     3,     'h11, 'hFF, 2,  0, 0, 0,   0,  0,   0};
    vt[2] = '{1,   0,  1,  8,     4,     'h3C, 'h55, 4,  1, 5, 0,   0,  0,   0};
    vt[3] = '{0,   0,  2,  2,     3,     'h10, 'h20, 0,  2, 3, 0,   0,  0,   0};
    vt[4] = '{1,   0,  0,  64,    5,     'hA5, 'h5A, 3,  0, 0, 10,  0,  0,   0};
    vt[5] = '{1,   1,  0,  1,     3,     'h01, 'hC3, 5,  0, 0, 4,   0,  0,   0};
    vt[6] = '{0,   0,  6,  0,     0,     'h7F, 'h80, 0,  0, 0, 0,   3,  0,   0};
    vt[7] = '{0,   0,  4,  'h200, 'h040, 'hF0, 'h00, 10, 0, 0, 0,   0,  686, 0};
    vt[8] = '{0,   0,  2,  'h200, 'h040, 'hF0, 'h00, 10, 0, 0, 0,   0,  0,   0};
    vt[9] = '{0,   0,  4,  2,     1,     'h00, 'hFF, 0,  0, 0, 0,   0,  0,   1};

    for (int i = 0; i < 10; i++) run_vec(i, vt[i]);

    repeat (3) @(negedge clk_sys);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete in time");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/frame_traffic_gen.md
FRAME_TRAFFIC_GEN -- requirements
Module: frame_traffic_gen

Interface
REQ-001 Parameter NUM_CLASSES, default 2: number of priority classes; class 0 is the highest priority.
REQ-002 Parameter CLASS_W, default 1: class index width, at least clog2(NUM_CLASSES), minimum 1.
REQ-003 Parameter DATA_W, default 8: payload width.
REQ-004 Parameter LEN_W, default 12: frame-length field width.
REQ-005 clk_sys  in  1: single clock; all logic on its rising edge.
REQ-006 reset  in  1: synchronous, active-high.
REQ-007 start  in  1: run request, sampled only in IDLE.
REQ-008 stop  in  1: finish the current frame, then return to IDLE.
REQ-009 hold  in  1: stall; freezes all counters while high.
REQ-010 mode  in  1: 0 = round-robin over all classes; 1 = fixed class.
REQ-011 fixed_class  in  CLASS_W: class used in mode 1, sampled at start.
REQ-012 num_frames  in  16: total frames per run; 0 = continuous.
REQ-013 len_cfg  in  NUM_CLASSES*LEN_W: per-class frame length; class k occupies slice k.
REQ-014 seed_cfg  in  NUM_CLASSES*DATA_W: per-class first payload value.
REQ-015 gap_cfg  in  8: idle cycles inserted after each round.
REQ-016 data_out  out  DATA_W: payload byte.
REQ-017 data_valid  out  1: payload cycle.
REQ-018 frame_valid  out  1: first payload cycle of a frame only.
REQ-019 ctrl_out  out  2*LEN_W: {len,len} on the frame_valid cycle; 0 otherwise.
REQ-020 prio_out  out  CLASS_W: class of the current frame.
REQ-021 hi_priority  out  1: asserted when prio_out == 0 while data_valid is high.
REQ-022 busy  out  1: high in any state other than IDLE.
REQ-023 done  out  1: one-cycle pulse when a run ends.
REQ-024 frame_cnt  out  16: frames completed in the current run.

Function
REQ-025 FSM states: IDLE, FRAME, GAP; all outputs registered.
REQ-026 IDLE→FRAME on start; the first data_valid occurs the cycle after start is sampled; a start seen while busy is ignored.
REQ-027 Configuration (mode, fixed_class, num_frames, len_cfg, seed_cfg, gap_cfg) is latched at start; changes during a run have no effect.
REQ-028 Effective frame length L is len_cfg[k]; L=0 is treated as 1.
REQ-029 FRAME drives data_valid=1 for L non-hold cycles and frame_valid=1 on the first of them only.
REQ-030 data_out during a frame is constant: (seed_k + n_k) mod 2^DATA_W, where n_k counts frames already sent for class k; data_out=0 when data_valid=0.
REQ-031 hold=1 drives data_valid, frame_valid and ctrl_out to 0 and freezes the beat, gap and frame counters; a held first beat delays frame_valid until the first non-held beat.
REQ-032 Mode 0 class order is 0,1,…,NUM_CLASSES-1, then wraps; consecutive frames within a round are back-to-back with no idle cycle.
REQ-033 Mode 0: after class NUM_CLASSES-1 ends, enter GAP for gap_cfg cycles. Mode 1: enter GAP after every frame.
REQ-034 gap_cfg=0 bypasses GAP; the next frame_valid follows the previous last beat directly.
REQ-035 frame_cnt increments on the last beat of each frame.
REQ-036 If num_frames≠0 and frame_cnt reaches num_frames: go to IDLE with no trailing gap, pulse done, hold frame_cnt until the next start.
REQ-037 stop asserted in FRAME: the frame completes, then IDLE and done. stop asserted in GAP: immediate IDLE and done.
REQ-038 frame_cnt wraps from 0xFFFF to 0 in continuous mode.
REQ-039 When start and stop are both high in IDLE, start wins and stop is ignored.

Reset
REQ-040 reset forces IDLE and sets every output, n_k, frame_cnt and all internal counters to 0, on the edge where it is sampled, including mid-frame.
REQ-041 After reset is released, the block waits in IDLE for start; no partial frame resumes.

Verification
REQ-042 NUM_CLASSES=2, len {0x200,0x040}, seeds {0xF0,0x00}, gap 10, num_frames 4, mode 0 -> class 0: 512 beats, data 0xF0, ctrl 0x200200, hi_priority=1; then immediately class 1: 64 beats, data 0x00, ctrl 0x040040; then 10 idle cycles; then class 0 data 0xF1 and class 1 data 0x01; done after the 4th frame with no gap, frame_cnt=4.
REQ-043 Mode 1, fixed_class 1, seed 0xFF, len 3, gap 2, num_frames 2 -> data 0xFF×3, 2 idle cycles, 0x00×3, done.
REQ-044 hold high for 5 cycles on beat 1 of an 8-beat frame -> 8 valid beats total, frame_valid once, frame length extended by 5 cycles.
REQ-045 stop at beat 10 of 64, num_frames=0 -> beats 11–64 still sent, then IDLE and done; no next frame.
REQ-046 reset at beat 100 of 512 -> all outputs 0 next cycle, busy=0; next start restarts with seed values (n_k=0).
REQ-047 len 0, gap 0, second start pulse mid-run -> 1-beat frames back-to-back; the second start has no effect.
